// File: rtl/sc_backg_timer.sv
// Background speed timer: counts upcount strobes against compare>>level and raises
// an active-low timeout that stays asserted until the shifter acknowledges it.
module sc_backg_timer #(
  parameter logic [7:0] COMPARE_RESET    = 8'd200,
  parameter int         SHIFTS_PER_LEVEL = 8
) (
  input  logic       SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic       SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic       clear_InLow,
  input  logic       load_InLow,
  input  logic [7:0] loadData_In,
  input  logic       upcount_InLow,
  input  logic [1:0] shiftselection_In,
  output logic       T0_OutLow,
  output logic [7:0] count_Out,
  output logic [2:0] level_Out,
  output logic       overrun_Out
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [2:0] SHIFT_LAST = 3'(SHIFTS_PER_LEVEL - 1);
  localparam logic [2:0] LEVEL_MAX  = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] compare_q, compare_d;
  logic [2:0] level_q, level_d;
  logic [2:0] shiftcnt_q, shiftcnt_d;
  logic       overrun_q, overrun_d;

  logic [7:0] shifted, term, term_m1;
  logic       do_clear, do_load, do_tick, timeout, ack;

  // Terminal never drops to zero, otherwise a deep level would stall the counter.
  assign shifted = compare_q >> level_q;
  assign term    = (shifted == 8'd0) ? 8'd1 : shifted;
  assign term_m1 = term - 8'd1;

  assign do_clear = ~clear_InLow;
  assign do_load  = ~do_clear & ~load_InLow;
  assign do_tick  = ~do_clear & ~do_load & ~upcount_InLow;
  assign timeout  = do_tick & (count_q >= term_m1);
  assign ack      = (shiftselection_In == 2'b10);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    compare_d  = compare_q;
    level_d    = level_q;
    shiftcnt_d = shiftcnt_q;
    overrun_d  = overrun_q;

    if (do_clear) begin
      state_d    = RUN;
      count_d    = 8'd0;
      level_d    = 3'd0;
      shiftcnt_d = 3'd0;
      overrun_d  = 1'b0;
    end else if (do_load) begin
      // A load cycle freezes the handshake; an ack presented now is not taken.
      compare_d = (loadData_In == 8'd0) ? 8'd1 : loadData_In;
      count_d   = 8'd0;
    end else begin
      if (do_tick) begin
        count_d = timeout ? 8'd0 : count_q + 8'd1;
      end
      case (state_q)
        RUN: begin
          if (timeout) begin
            state_d = PEND;
          end
        end
        PEND: begin
          if (ack) begin
            if (!timeout) begin
              state_d = RUN;
            end
            if (shiftcnt_q == SHIFT_LAST) begin
              shiftcnt_d = 3'd0;
              if (level_q != LEVEL_MAX) begin
                level_d = level_q + 3'd1;
              end
            end else begin
              shiftcnt_d = shiftcnt_q + 3'd1;
            end
          end else if (timeout) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state_q    <= RUN;
      count_q    <= 8'd0;
      compare_q  <= COMPARE_RESET;
      level_q    <= 3'd0;
      shiftcnt_q <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      level_q    <= level_d;
      shiftcnt_q <= shiftcnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign T0_OutLow   = (state_q != PEND);
  assign count_Out   = count_q;
  assign level_Out   = level_q;
  assign overrun_Out = overrun_q;

endmodule

// File: tb/tb_sc_backg_timer.sv
// Directed bench for sc_backg_timer: linear stimulus, hand-computed expectations
// checked with immediate assertions.
module tb_sc_backg_timer;

  logic       clk;
  logic       rst;
  logic       clear_n;
  logic       load_n;
  logic [7:0] ldat;
  logic       up_n;
  logic [1:0] sh;
  logic       t0;
  logic [7:0] cnt;
  logic [2:0] lvl;
  logic       ovr;

  int tests = 0;
  int fails = 0;
  int n;
  int exp_n;
  int exp_lvl;

  sc_backg_timer dut (
    .SC_STATEMACHINEBACKG_CLOCK_50     (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh (rst),
    .clear_InLow                       (clear_n),
    .load_InLow                        (load_n),
    .loadData_In                       (ldat),
    .upcount_InLow                     (up_n),
    .shiftselection_In                 (sh),
    .T0_OutLow                         (t0),
    .count_Out                         (cnt),
    .level_Out                         (lvl),
    .overrun_Out                       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_n = 1'b0;
    ldat   = v;
    step();
    load_n = 1'b1;
  endtask

  task automatic tick();
    up_n = 1'b0;
    step();
    up_n = 1'b1;
  endtask

  task automatic do_ack();
    sh = 2'b10;
    step();
    sh = 2'b00;
  endtask

  task automatic do_clear();
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
  endtask

  // Ticks until T0 drops; returns the tick count, or the bound if it never drops.
  task automatic run_to_timeout(input int bound, output int ticks);
    ticks = 0;
    while (t0 !== 1'b0 && ticks < bound) begin
      tick();
      ticks++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    clear_n = 1'b1;
    load_n  = 1'b1;
    ldat    = 8'd0;
    up_n    = 1'b1;
    sh      = 2'b00;
    #12;
    chk("rst_t0", t0, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_lvl", lvl, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;

    // Load 4 and count to the first timeout.
    do_load(8'd4);
    chk("load4_cnt", cnt, 0);
    up_n = 1'b0;
    step(); chk("cnt1", cnt, 1); chk("cnt1_t0", t0, 1);
    step(); chk("cnt2", cnt, 2);
    step(); chk("cnt3", cnt, 3); chk("cnt3_t0", t0, 1);
    step(); chk("cnt_wrap", cnt, 0); chk("to_t0", t0, 0);
    up_n = 1'b1;
    step(); step();
    chk("to_held", t0, 0);

    do_ack();
    chk("ack_t0", t0, 1);
    chk("ack_cnt", cnt, 0);

    // Overrun: timeout while already pending.
    run_to_timeout(9, n);
    chk("c4_ticks", n, 4);
    up_n = 1'b0;
    step(); step(); step();
    chk("ovr_before", ovr, 0);
    step();
    chk("ovr_set", ovr, 1);
    chk("ovr_t0", t0, 0);
    step(); step(); step(); step();
    chk("ovr_sticky", ovr, 1);
    chk("ovr_cnt", cnt, 0);
    // Clear wins over a simultaneous load and tick, and keeps compare.
    clear_n = 1'b0; load_n = 1'b0; ldat = 8'd2;
    step();
    clear_n = 1'b1; load_n = 1'b1; up_n = 1'b1;
    chk("clr_ovr", ovr, 0);
    chk("clr_t0", t0, 1);
    chk("clr_cnt", cnt, 0);
    chk("clr_lvl", lvl, 0);
    run_to_timeout(9, n);
    chk("clr_keeps_cmp", n, 4);

    // Level progression with compare 8; the RUN-state ack must not count.
    do_clear();
    do_load(8'd8);
    do_ack();
    chk("run_ack_t0", t0, 1);
    for (int p = 1; p <= 64; p++) begin
      exp_lvl = (p - 1) / 8;
      if (exp_lvl > 7) exp_lvl = 7;
      exp_n = 8 >> exp_lvl;
      if (exp_n == 0) exp_n = 1;
      run_to_timeout(exp_n + 5, n);
      chk($sformatf("pair%0d_ticks", p), n, exp_n);
      do_ack();
      chk($sformatf("pair%0d_t0", p), t0, 1);
      exp_lvl = p / 8;
      if (exp_lvl > 7) exp_lvl = 7;
      chk($sformatf("pair%0d_lvl", p), lvl, exp_lvl);
    end

    // Level change lowers terminal below the count held while pending.
    do_clear();
    do_load(8'd8);
    for (int p = 1; p <= 7; p++) begin
      run_to_timeout(13, n);
      do_ack();
    end
    chk("pre_lvl", lvl, 0);
    run_to_timeout(13, n);
    chk("pre_ticks", n, 8);
    for (int i = 0; i < 5; i++) tick();
    chk("pend_count", cnt, 5);
    chk("pend_t0", t0, 0);
    do_ack();
    chk("lower_lvl", lvl, 1);
    chk("lower_cnt", cnt, 5);
    chk("lower_t0", t0, 1);
    tick();
    chk("lower_wrap", cnt, 0);
    chk("lower_t0b", t0, 0);

    // Ack coincident with a terminal tick.
    do_clear();
    do_load(8'd4);
    run_to_timeout(9, n);
    tick(); tick(); tick();
    chk("co_cnt3", cnt, 3);
    up_n = 1'b0; sh = 2'b10;
    step();
    up_n = 1'b1; sh = 2'b00;
    chk("co_cnt", cnt, 0);
    chk("co_t0", t0, 0);
    chk("co_ovr", ovr, 0);
    step();
    chk("co_t0b", t0, 0);
    do_ack();
    chk("co_rel", t0, 1);

    // Load 0 is stored as 1: every tick is terminal.
    do_load(8'd0);
    tick();
    chk("z_cnt", cnt, 0);
    chk("z_t0", t0, 0);
    tick();
    chk("z_ovr", ovr, 1);
    // Load beats a tick and keeps pending state and overrun.
    do_load(8'd4);
    tick();
    chk("l4_cnt", cnt, 1);
    load_n = 1'b0; ldat = 8'd4; up_n = 1'b0;
    step();
    load_n = 1'b1; up_n = 1'b1;
    chk("ld_notick", cnt, 0);
    chk("ld_t0", t0, 0);
    chk("ld_ovr", ovr, 1);

    // Asynchronous reset while pending, then default compare.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_t0", t0, 1);
    chk("arst_cnt", cnt, 0);
    chk("arst_ovr", ovr, 0);
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_cnt", cnt, 1);
    run_to_timeout(210, n);
    chk("dflt_cmp", n, 199);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
